// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elevator_pkg
// Description : Constants and helpers shared by the elevator controller and
//               the car position model: motor command encodings, floor count
//               and the one-hot floor decode.
// Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  typedef enum logic [1:0] {
    MOTOR_IDLE    = 2'b00,
    MOTOR_ILLEGAL = 2'b01,
    MOTOR_UP      = 2'b10,
    MOTOR_DOWN    = 2'b11
  } motor_cmd_t;

  // Floor number 1..NUM_FLOORS to one-hot sensor vector; anything else decodes to zero
  function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] floor);
    logic [NUM_FLOORS-1:0] vec;
    case (floor)
      2'd1:    vec = 3'b001;
      2'd2:    vec = 3'b010;
      2'd3:    vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/car_position_model_if.sv
`default_nettype none
// ============================================================================
// Module      : car_position_model_if
// Description : Link between the movement controller (master: strobe and
//               motor command) and the car model (slave: floor sensors,
//               position and fault status).
// Revision    : 1.0 - initial release
// ============================================================================
interface car_position_model_if #(
  parameter int TICKS_PER_FLOOR = 8
) ();
  import elevator_pkg::*;

  localparam int SUB_W = $clog2(TICKS_PER_FLOOR);

  logic                  tick_en;
  logic [1:0]            motor;
  logic [NUM_FLOORS-1:0] loc;
  logic                  between;
  logic [1:0]            floor_idx;
  logic [SUB_W-1:0]      sub_pos;
  logic                  fault;

  modport master (
    output tick_en, motor,
    input  loc, between, floor_idx, sub_pos, fault
  );

  modport slave (
    input  tick_en, motor,
    output loc, between, floor_idx, sub_pos, fault
  );

endinterface
`default_nettype wire

// File: rtl/car_position_model_floor_span_counter.sv
`default_nettype none
// ============================================================================
// Module      : floor_span_counter
// Description : Up/down counter of ticks travelled above the current floor.
//               Wraps MAX-1 -> 0 on inc (wrap) and 0 -> MAX-1 on dec (borrow)
//               so the owner can step its floor index.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_span_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         wrap,
  output logic         borrow
);

  localparam logic [W-1:0] TOP = W'(MAX - 1);

  assign wrap   = inc && (count == TOP);
  assign borrow = dec && !inc && (count == '0);

  // Next count; inc wins should both ever be asserted
  always_comb begin
    count_nxt = count;
    if (inc) begin
      count_nxt = wrap ? '0 : count + 1'b1;
    end else if (dec) begin
      count_nxt = borrow ? TOP : count - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/car_position_model.sv
`default_nettype none
// ============================================================================
// Module      : car_position_model
// Description : Shaft/car model downstream of the movement controller.
//               Integrates strobed motor commands into (floor_idx, sub_pos),
//               decodes the one-hot floor sensors and flags illegal commands
//               and over-travel with a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module car_position_model
  import elevator_pkg::*;
#(
  parameter int TICKS_PER_FLOOR = 8,
  parameter int START_FLOOR     = 1
) (
  input logic               clk,
  input logic               RST,
  car_position_model_if.slave bus
);

  localparam int         SUB_W = $clog2(TICKS_PER_FLOOR);
  localparam logic [1:0] START = 2'(START_FLOOR);
  localparam logic [1:0] TOP_FLOOR = 2'(NUM_FLOORS);

  logic [1:0]            floor_idx;
  logic [NUM_FLOORS-1:0] loc;
  logic                  between;
  logic                  fault;

  logic [SUB_W-1:0]      sub_pos;
  logic [SUB_W-1:0]      sub_nxt;
  logic                  wrap;
  logic                  borrow;
  logic [1:0]            floor_nxt;

  // Motor is only looked at on strobe cycles
  logic strobe_up, strobe_down, strobe_bad;
  logic at_top, at_bottom;
  logic inc, dec, fault_set;

  assign strobe_up   = bus.tick_en && (bus.motor == MOTOR_UP);
  assign strobe_down = bus.tick_en && (bus.motor == MOTOR_DOWN);
  assign strobe_bad  = bus.tick_en && (bus.motor == MOTOR_ILLEGAL);

  // End-floor alignment blocks further travel outward
  assign at_top    = (floor_idx == TOP_FLOOR) && (sub_pos == '0);
  assign at_bottom = (floor_idx == 2'd1)      && (sub_pos == '0);

  assign inc       = strobe_up   && !at_top;
  assign dec       = strobe_down && !at_bottom;
  assign fault_set = strobe_bad || (strobe_up && at_top) || (strobe_down && at_bottom);

  floor_span_counter #(
    .MAX (TICKS_PER_FLOOR),
    .W   (SUB_W)
  ) u_span (
    .clk       (clk),
    .rst       (RST),
    .inc       (inc),
    .dec       (dec),
    .count     (sub_pos),
    .count_nxt (sub_nxt),
    .wrap      (wrap),
    .borrow    (borrow)
  );

  // Floor index steps when the span counter crosses a floor boundary
  always_comb begin
    floor_nxt = floor_idx;
    if (wrap) begin
      floor_nxt = floor_idx + 2'd1;
    end else if (borrow) begin
      floor_nxt = floor_idx - 2'd1;
    end
  end

  // Position, sensor decode and sticky fault registers
  always_ff @(posedge clk) begin
    if (RST) begin
      floor_idx <= START;
      loc       <= floor_onehot(START);
      between   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      floor_idx <= floor_nxt;
      loc       <= (sub_nxt == '0) ? floor_onehot(floor_nxt) : '0;
      between   <= (sub_nxt != '0);
      fault     <= fault || fault_set;
    end
  end

  assign bus.floor_idx = floor_idx;
  assign bus.sub_pos   = sub_pos;
  assign bus.loc       = loc;
  assign bus.between   = between;
  assign bus.fault     = fault;

endmodule
`default_nettype wire

// File: tb/tb_car_position_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_car_position_model
// Description : Directed bench for car_position_model with a linear-position
//               reference model and literal checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_car_position_model;

  localparam int T     = 4;
  localparam int START = 1;

  logic clk = 1'b0;
  logic RST = 1'b1;

  always #5 clk = ~clk;

  car_position_model_if #(.TICKS_PER_FLOOR(T)) bus ();

  car_position_model #(
    .TICKS_PER_FLOOR (T),
    .START_FLOOR     (START)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference: car height measured in ticks from floor 1, range 0..2*T
  int m_pos   = 0;
  int m_fault = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (RST) begin
      m_pos   = (START - 1) * T;
      m_fault = 0;
      m_valid = 1'b1;
    end else if (bus.tick_en) begin
      case (bus.motor)
        2'b10: if (m_pos == 2 * T) m_fault = 1; else m_pos = m_pos + 1;
        2'b11: if (m_pos == 0)     m_fault = 1; else m_pos = m_pos - 1;
        2'b01: m_fault = 1;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference
  always @(negedge clk) begin
    if (m_valid) begin
      int fl, sp, lc;
      fl = m_pos / T + 1;
      sp = m_pos % T;
      lc = (sp == 0) ? (1 << (fl - 1)) : 0;
      check("model_floor_idx", int'(bus.floor_idx), fl);
      check("model_sub_pos",   int'(bus.sub_pos),   sp);
      check("model_loc",       int'(bus.loc),       lc);
      check("model_between",   int'(bus.between),   (sp != 0) ? 1 : 0);
      check("model_fault",     int'(bus.fault),     m_fault);
    end
  end

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic step(input logic te, input logic [1:0] m, input logic r);
    bus.tick_en = te;
    bus.motor   = m;
    RST         = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.tick_en = 1'b0;
    bus.motor   = 2'b00;
    step(0, 2'b00, 1);
    step(0, 2'b00, 1);
    RST = 1'b0;

    // Reset state
    check("rst_loc",   int'(bus.loc),       3'b001);
    check("rst_btw",   int'(bus.between),   0);
    check("rst_fault", int'(bus.fault),     0);
    check("rst_floor", int'(bus.floor_idx), 1);

    // Up one floor: between for 3 strobes, aligned at floor 2 after the 4th
    for (int i = 1; i <= 3; i++) begin
      step(1, 2'b10, 0);
      check("up1_loc", int'(bus.loc), 3'b000);
      step(0, 2'b00, 0);
    end
    step(1, 2'b10, 0);
    check("up1_arrive_loc", int'(bus.loc), 3'b010);
    for (int i = 0; i < 4; i++) step(1, 2'b10, 0);
    check("up2_loc",   int'(bus.loc),       3'b100);
    check("up2_floor", int'(bus.floor_idx), 3);

    // Over-travel at the top
    step(1, 2'b10, 0);
    check("ot_loc",   int'(bus.loc),   3'b100);
    check("ot_fault", int'(bus.fault), 1);
    for (int i = 0; i < 4; i++) step(1, 2'b11, 0);
    check("dn_loc",   int'(bus.loc),   3'b010);
    check("dn_fault", int'(bus.fault), 1);

    // Mid-span reversal from floor 1
    step(0, 2'b00, 1);
    RST = 1'b0;
    step(1, 2'b10, 0); check("rev_sub1", int'(bus.sub_pos), 1);
    step(1, 2'b10, 0); check("rev_sub2", int'(bus.sub_pos), 2);
    step(1, 2'b11, 0); check("rev_sub3", int'(bus.sub_pos), 1);
    step(1, 2'b11, 0); check("rev_sub4", int'(bus.sub_pos), 0);
    check("rev_loc",   int'(bus.loc),   3'b001);
    check("rev_fault", int'(bus.fault), 0);

    // Motor held without strobe, then glitches between strobes
    for (int i = 0; i < 20; i++) step(0, 2'b10, 0);
    check("nostrobe_loc", int'(bus.loc),     3'b001);
    check("nostrobe_sub", int'(bus.sub_pos), 0);
    step(0, 2'b01, 0);
    step(0, 2'b11, 0);
    check("glitch_fault", int'(bus.fault), 0);
    step(1, 2'b01, 0);
    check("illegal_fault", int'(bus.fault), 1);
    check("illegal_loc",   int'(bus.loc),   3'b001);

    // Legal motion continues after a fault
    step(1, 2'b10, 0);
    step(1, 2'b10, 0);
    check("postfault_sub", int'(bus.sub_pos), 2);
    check("postfault_btw", int'(bus.between), 1);

    // Reset wins over a strobe mid-span
    step(1, 2'b10, 1);
    RST = 1'b0;
    bus.tick_en = 1'b0;
    check("rstmid_floor", int'(bus.floor_idx), START);
    check("rstmid_sub",   int'(bus.sub_pos),   0);
    check("rstmid_loc",   int'(bus.loc),       3'b001);
    check("rstmid_fault", int'(bus.fault),     0);

    // Under-travel at the bottom
    step(1, 2'b11, 0);
    check("ut_fault", int'(bus.fault), 1);
    check("ut_loc",   int'(bus.loc),   3'b001);

    // Descend across a floor boundary via borrow
    for (int i = 0; i < 5; i++) step(1, 2'b10, 0);
    step(1, 2'b11, 0);
    check("borrow_floor", int'(bus.floor_idx), 2);
    step(1, 2'b11, 0);
    check("borrow_floor2", int'(bus.floor_idx), 1);
    check("borrow_sub",    int'(bus.sub_pos),   3);

    step(0, 2'b00, 0);
    step(0, 2'b00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
